// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus seen by the load/store unit.
// The slave modport is the LSU's view; master is the environment (pipeline + memory).
interface load_store_unit_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              op_write;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              busy;
  logic              err;
  logic              mem_rd_wr;
  logic [ADDR_W-3:0] mem_endereco;
  logic [31:0]       mem_entrada;
  logic [31:0]       mem_saida;

  modport master (
    output start, op_write, size, sign_ext, addr, wdata, mem_saida,
    input  rdata, done, busy, err, mem_rd_wr, mem_endereco, mem_entrada
  );

  modport slave (
    input  start, op_write, size, sign_ext, addr, wdata, mem_saida,
    output rdata, done, busy, err, mem_rd_wr, mem_endereco, mem_entrada
  );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian byte/half/word load-store front end for a word-only memory; sub-word stores use read-modify-write.
// done after 3 (load), 2 (word store), 4 (sub-word store) or 1 (misaligned) cycles; start is ignored while busy.
module load_store_unit #(
  parameter int ADDR_W = 12
) (
  input logic              Clk,
  input logic              Rst_n,
  load_store_unit_if.slave lsu
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE, ERR} state_t;

  state_t            state;
  logic              op_write_q;
  logic              sign_ext_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [31:0]       mem_entrada_q;
  logic [ADDR_W-3:0] mem_endereco_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;

  logic              misaligned;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  always_comb begin
    misaligned = (lsu.size == 2'b11) ||
                 (lsu.size == 2'b01 && lsu.addr[0]) ||
                 (lsu.size == 2'b10 && lsu.addr[1:0] != 2'b00);
  end

  // Lane 0 is the most significant byte of the word.
  always_comb begin
    lane_byte = lsu.mem_saida[31:24];
    case (off_q)
      2'd0: lane_byte = lsu.mem_saida[31:24];
      2'd1: lane_byte = lsu.mem_saida[23:16];
      2'd2: lane_byte = lsu.mem_saida[15:8];
      2'd3: lane_byte = lsu.mem_saida[7:0];
      default: lane_byte = lsu.mem_saida[31:24];
    endcase
    lane_half = off_q[1] ? lsu.mem_saida[15:0] : lsu.mem_saida[31:16];

    load_val = lsu.mem_saida;
    case (size_q)
      2'b00: load_val = {{24{sign_ext_q & lane_byte[7]}}, lane_byte};
      2'b01: load_val = {{16{sign_ext_q & lane_half[15]}}, lane_half};
      default: load_val = lsu.mem_saida;
    endcase
  end

  always_comb begin
    merged = lsu.mem_saida;
    case (size_q)
      2'b00: begin
        case (off_q)
          2'd0: merged[31:24] = wdata_q[7:0];
          2'd1: merged[23:16] = wdata_q[7:0];
          2'd2: merged[15:8]  = wdata_q[7:0];
          2'd3: merged[7:0]   = wdata_q[7:0];
          default: merged = lsu.mem_saida;
        endcase
      end
      2'b01: begin
        if (off_q[1]) merged[15:0]  = wdata_q;
        else          merged[31:16] = wdata_q;
      end
      default: merged = lsu.mem_saida;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= IDLE;
      op_write_q     <= 1'b0;
      sign_ext_q     <= 1'b0;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      wdata_q        <= 16'h0;
      rdata_q        <= 32'h0;
      mem_entrada_q  <= 32'h0;
      mem_endereco_q <= '0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu.start) begin
            op_write_q     <= lsu.op_write;
            sign_ext_q     <= lsu.sign_ext;
            size_q         <= lsu.size;
            off_q          <= lsu.addr[1:0];
            wdata_q        <= lsu.wdata[15:0];
            mem_endereco_q <= lsu.addr[ADDR_W-1:2];
            busy_q         <= 1'b1;
            if (misaligned) begin
              state  <= ERR;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (lsu.op_write && lsu.size == 2'b10) begin
              state         <= WR;
              mem_entrada_q <= lsu.wdata;
            end else begin
              state <= RD;
            end
          end
        end
        RD: state <= CAP;
        CAP: begin
          if (!op_write_q) begin
            rdata_q <= load_val;
            done_q  <= 1'b1;
            state   <= DONE;
          end else begin
            mem_entrada_q <= merged;
            state         <= WR;
          end
        end
        WR: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE, ERR: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Write enable comes straight from the state so it can never glitch high outside WR.
  assign lsu.mem_rd_wr    = (state == WR);
  assign lsu.mem_endereco = mem_endereco_q;
  assign lsu.mem_entrada  = mem_entrada_q;
  assign lsu.rdata        = rdata_q;
  assign lsu.done         = done_q;
  assign lsu.busy         = busy_q;
  assign lsu.err          = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-array memory model, per-cycle comparison against a behavioural
// reference (latency, lane/extension arithmetic, read-modify-write result), directed and random requests.
module tb_load_store_unit;

  logic Clk = 1'b0;
  logic Rst_n;

  load_store_unit_if #(.ADDR_W(12)) intf ();

  load_store_unit #(.ADDR_W(12)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .lsu   (intf.slave)
  );

  always #5 Clk = ~Clk;

  int          checks;
  int          errors;
  int          cyc;
  logic [31:0] mem_arr [0:1023];
  logic [31:0] ref_mem [0:1023];
  bit          mem_ready;

  // Expectations for the transaction in flight
  bit          t_active;
  int          t0;
  int          t_lat;
  bit          t_err;
  bit          t_load;
  bit          t_wr;
  logic [31:0] t_rdata;
  logic [31:0] t_newword;
  logic [9:0]  t_idx;
  logic [31:0] model_rdata;
  int          last_done_n;
  int          wr_pulses;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'h000007D1;
      1: return 32'h00000FA1;
      2: return 32'h00001389;
      3: return 32'h00000BB9;
      default: return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  initial forever begin
    @(posedge Clk);
    cyc <= cyc + 1;
  end

  // Data memory: one-cycle registered read, write on mem_rd_wr
  initial forever begin
    @(posedge Clk);
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else begin
      if (intf.mem_rd_wr) mem_arr[intf.mem_endereco] <= intf.mem_entrada;
      intf.mem_saida <= mem_arr[intf.mem_endereco];
    end
  end

  // Per-cycle compare against the reference expectations
  initial forever begin : compare
    int          n;
    bit          exp_done;
    bit          exp_busy;
    bit          exp_wr;
    logic [31:0] exp_rdata;
    @(negedge Clk);
    if (!Rst_n) begin
      chk("rst_flags", {28'h0, intf.done, intf.busy, intf.err, intf.mem_rd_wr}, 32'h0);
      chk("rst_rdata", intf.rdata, 32'h0);
      chk("rst_addr", 32'(intf.mem_endereco), 32'h0);
      chk("rst_entrada", intf.mem_entrada, 32'h0);
    end else begin
      n         = cyc - t0 + 1;
      exp_done  = t_active && (n == t_lat);
      exp_busy  = t_active && (n <= t_lat);
      exp_wr    = t_active && t_wr && (n == t_lat - 1);
      exp_rdata = (t_active && t_load && n >= t_lat) ? t_rdata : model_rdata;
      if (t_active && intf.done) last_done_n = n;
      if (t_active && intf.mem_rd_wr) wr_pulses++;
      chk("done", 32'(intf.done), 32'(exp_done));
      chk("busy", 32'(intf.busy), 32'(exp_busy));
      chk("err", 32'(intf.err), 32'(exp_done && t_err));
      chk("mem_rd_wr", 32'(intf.mem_rd_wr), 32'(exp_wr));
      chk("rdata", intf.rdata, exp_rdata);
      if (exp_wr) begin
        chk("wr_addr", 32'(intf.mem_endereco), 32'(t_idx));
        chk("wr_data", intf.mem_entrada, t_newword);
      end
    end
  end

  task automatic do_txn(input bit wr, input logic [1:0] sz, input bit sx,
                        input logic [11:0] a, input logic [31:0] wd, input bit noise);
    bit          mis;
    logic [9:0]  idx;
    int          nb;
    int          sh;
    logic [31:0] mask;
    logic [31:0] word;
    logic [31:0] v;
    @(negedge Clk);
    #2;
    mis  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    idx  = a[11:2];
    nb   = (sz == 2'b00) ? 8 : (sz == 2'b01) ? 16 : 32;
    sh   = (sz == 2'b00) ? 8 * (3 - int'(a[1:0])) : (sz == 2'b01) ? (a[1] ? 0 : 16) : 0;
    mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'h1 << nb) - 32'h1);
    word = ref_mem[idx];
    v    = (word >> sh) & mask;
    if (sx && nb < 32 && v[nb-1]) v = v | ~mask;
    t_rdata     = v;
    t_newword   = (word & ~(mask << sh)) | ((wd & mask) << sh);
    t_idx       = idx;
    t_err       = mis;
    t_load      = !mis && !wr;
    t_wr        = !mis && wr;
    t_lat       = mis ? 1 : (!wr ? 3 : ((sz == 2'b10) ? 2 : 4));
    last_done_n = -1;
    wr_pulses   = 0;
    t0          = cyc + 1;
    t_active    = 1'b1;
    intf.start    = 1'b1;
    intf.op_write = wr;
    intf.size     = sz;
    intf.sign_ext = sx;
    intf.addr     = a;
    intf.wdata    = wd;
    @(posedge Clk);
    #1;
    intf.start = 1'b0;
    for (int i = 1; i <= t_lat; i++) begin
      @(negedge Clk);
      if (noise && i < t_lat) begin
        #2;
        intf.start    = 1'b1;
        intf.op_write = 1'($urandom);
        intf.size     = 2'($urandom);
        intf.sign_ext = 1'($urandom);
        intf.addr     = 12'($urandom);
        intf.wdata    = $urandom;
      end
    end
    #2;
    intf.start = 1'b0;
    t_active   = 1'b0;
    if (t_load) model_rdata = t_rdata;
    if (t_wr) ref_mem[idx] = t_newword;
    chk("mem_word", mem_arr[idx], ref_mem[idx]);
  endtask

  initial begin : main
    int nbad;
    Rst_n         = 1'b0;
    intf.start    = 1'b0;
    intf.op_write = 1'b0;
    intf.size     = 2'b00;
    intf.sign_ext = 1'b0;
    intf.addr     = 12'h0;
    intf.wdata    = 32'h0;
    model_rdata   = 32'h0;
    t0            = 0;
    t_lat         = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge Clk);
    #2 Rst_n = 1'b1;

    do_txn(1'b0, 2'b10, 1'b0, 12'h004, 32'h0, 1'b0);
    chk("tp_word_load", intf.rdata, 32'h00000FA1);
    chk("tp_word_load_model", model_rdata, 32'h00000FA1);
    chk("tp_word_load_lat", last_done_n, 3);
    chk("tp_word_load_wr", wr_pulses, 0);

    do_txn(1'b0, 2'b00, 1'b1, 12'h00B, 32'h0, 1'b1);
    chk("tp_byte_sx", intf.rdata, 32'hFFFFFF89);
    do_txn(1'b0, 2'b00, 1'b0, 12'h00B, 32'h0, 1'b0);
    chk("tp_byte_zx", intf.rdata, 32'h00000089);
    do_txn(1'b0, 2'b00, 1'b1, 12'h008, 32'h0, 1'b0);
    chk("tp_byte_zero", intf.rdata, 32'h00000000);

    do_txn(1'b1, 2'b01, 1'b0, 12'h00C, 32'h0000ABCD, 1'b1);
    chk("tp_half_st_wr", wr_pulses, 1);
    chk("tp_half_st_lat", last_done_n, 4);
    chk("tp_half_st_rdata", intf.rdata, 32'h00000000);
    do_txn(1'b0, 2'b10, 1'b0, 12'h00C, 32'h0, 1'b0);
    chk("tp_half_st_rb", intf.rdata, 32'hABCD0BB9);

    do_txn(1'b1, 2'b00, 1'b0, 12'h001, 32'h000000EE, 1'b0);
    chk("tp_byte_st_mem", mem_arr[0], 32'h00EE07D1);
    do_txn(1'b1, 2'b10, 1'b0, 12'h000, 32'hDEADBEEF, 1'b1);
    chk("tp_word_st_lat", last_done_n, 2);
    do_txn(1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 1'b0);
    chk("tp_word_st_rb", intf.rdata, 32'hDEADBEEF);

    do_txn(1'b0, 2'b10, 1'b0, 12'h006, 32'h0, 1'b0);
    chk("tp_mis_word_lat", last_done_n, 1);
    do_txn(1'b1, 2'b01, 1'b0, 12'h003, 32'h12345678, 1'b0);
    chk("tp_mis_half_wr", wr_pulses, 0);
    chk("tp_mis_half_mem", mem_arr[0], 32'hDEADBEEF);
    do_txn(1'b1, 2'b11, 1'b0, 12'h000, 32'h0BADF00D, 1'b0);
    chk("tp_mis_size_lat", last_done_n, 1);
    chk("tp_mis_rdata_kept", intf.rdata, 32'hDEADBEEF);

    // Reset during CAP of a byte store to word 1
    @(negedge Clk);
    #2;
    t_wr = 1'b1; t_load = 1'b0; t_err = 1'b0; t_lat = 4; t_idx = 10'd1;
    t_newword = 32'h0; t0 = cyc + 1; t_active = 1'b1;
    intf.start = 1'b1; intf.op_write = 1'b1; intf.size = 2'b00;
    intf.addr = 12'h004; intf.wdata = 32'h00000055;
    @(posedge Clk);
    #1 intf.start = 1'b0;
    repeat (2) @(negedge Clk);
    #2;
    Rst_n       = 1'b0;
    t_active    = 1'b0;
    model_rdata = 32'h0;
    #1;
    chk("rst_mid_busy", 32'(intf.busy), 32'h0);
    chk("rst_mid_wr", 32'(intf.mem_rd_wr), 32'h0);
    repeat (2) @(negedge Clk);
    #2 Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    #2;
    chk("rst_mid_word1", mem_arr[1], 32'h00000FA1);

    for (int k = 0; k < 400; k++) begin
      do_txn(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 31)),
             $urandom, ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge Clk);
    nbad = 0;
    for (int i = 0; i < 1024; i++) if (mem_arr[i] !== ref_mem[i]) nbad++;
    chk("mem_sweep_bad_words", nbad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
